// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register-write scoreboard for an in-order issue stage.
// Tracks one pending-write bit per architectural register and the number of
// outstanding register-writing instructions, and holds back an instruction
// whose sources or destination are still pending, or whose write would
// exceed the in-flight limit.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid                 decoded instruction presented for issue
//   rs1_id/rs2_id/rd_id      register indices; use_rs1/use_rs2 qualify reads
//   reg_write                instruction writes rd
//   flush                    blocks issue this cycle, keeps tracked state
//   wb_valid, wb_rd          writeback completion of wb_rd
//   in_ready, issue_fire     combinational issue handshake
//   busy_vec, inflight       registered pending-write state
//   stall_cnt                registered saturating stall-cycle counter
//   wb_err                   registered sticky writeback-protocol error
module issue_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [4:0]                        rs1_id,
    input  logic [4:0]                        rs2_id,
    input  logic [4:0]                        rd_id,
    input  logic                              use_rs1,
    input  logic                              use_rs2,
    input  logic                              reg_write,
    input  logic                              flush,
    input  logic                              wb_valid,
    input  logic [4:0]                        wb_rd,
    output logic                              issue_fire,
    output logic [31:0]                       busy_vec,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic [CNT_W-1:0]                  stall_cnt,
    output logic                              wb_err
);

    localparam int unsigned IW  = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned IWX = IW + 1;

    logic        wb_clr;
    logic        wb_bad;
    logic        wr;
    logic        hazard;
    logic        slot_ok;
    logic [31:0] busy_eff;
    logic [31:0] busy_nxt;
    logic [IW-1:0] inflight_nxt;

    // Writeback decode and issue decision; a same-cycle writeback frees both
    // its register and its in-flight slot before the hazard check.
    always_comb begin
        wb_clr   = wb_valid && (wb_rd != 5'd0) && busy_vec[wb_rd];
        wb_bad   = wb_valid && (wb_rd != 5'd0) && !busy_vec[wb_rd];
        wr       = reg_write && (rd_id != 5'd0);
        busy_eff = busy_vec;
        if (wb_clr) begin
            busy_eff[wb_rd] = 1'b0;
        end
        hazard = (use_rs1 && (rs1_id != 5'd0) && busy_eff[rs1_id]) ||
                 (use_rs2 && (rs2_id != 5'd0) && busy_eff[rs2_id]) ||
                 (wr && busy_eff[rd_id]);
        // wb_clr implies inflight >= 1, so the subtraction cannot wrap.
        slot_ok    = (IWX'(inflight) - IWX'(wb_clr)) < IWX'(MAX_INFLIGHT);
        in_ready   = !flush && !hazard && (slot_ok || !wr);
        issue_fire = in_valid && in_ready && !rst;
    end

    // Next-state: an issue set wins over a writeback clear on the same index.
    always_comb begin
        busy_nxt = busy_eff;
        if (issue_fire && wr) begin
            busy_nxt[rd_id] = 1'b1;
        end
        busy_nxt[0]  = 1'b0;
        inflight_nxt = inflight + IW'(issue_fire && wr) - IW'(wb_clr);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec  <= '0;
            inflight  <= '0;
            stall_cnt <= '0;
            wb_err    <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            inflight <= inflight_nxt;
            if (in_valid && !in_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (wb_bad) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: directed scenarios plus a randomized run,
// all checked against a pending-register list model.
module tb_issue_scoreboard;

    localparam int unsigned MAX   = 4;
    localparam int unsigned CW    = 5;
    localparam int unsigned IW    = $clog2(MAX + 1);
    localparam int          SMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    rs1_id, rs2_id, rd_id, wb_rd;
    logic          use_rs1, use_rs2, reg_write, flush, wb_valid;
    logic          issue_fire;
    logic [31:0]   busy_vec;
    logic [IW-1:0] inflight;
    logic [CW-1:0] stall_cnt;
    logic          wb_err;

    int checks = 0;
    int errors = 0;

    // Reference model: unordered list of registers with a pending write.
    int pending[$];
    int stall_m = 0;
    bit err_m = 0;

    issue_scoreboard #(.MAX_INFLIGHT(MAX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .reg_write(reg_write),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .issue_fire(issue_fire), .busy_vec(busy_vec), .inflight(inflight),
        .stall_cnt(stall_cnt), .wb_err(wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_busy(int r);
        foreach (pending[i]) if (pending[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v;
        v = '0;
        foreach (pending[i]) v[pending[i]] = 1'b1;
        return v;
    endfunction

    // An operand blocks if its register is pending and not being written back now.
    function automatic bit m_ready();
        bit clr, wrm, h;
        int cnt;
        clr = wb_valid && wb_rd != 0 && m_busy(int'(wb_rd));
        wrm = reg_write && rd_id != 0;
        h = 1'b0;
        if (use_rs1 && rs1_id != 0 && m_busy(int'(rs1_id)) && !(clr && rs1_id == wb_rd)) h = 1'b1;
        if (use_rs2 && rs2_id != 0 && m_busy(int'(rs2_id)) && !(clr && rs2_id == wb_rd)) h = 1'b1;
        if (wrm && m_busy(int'(rd_id)) && !(clr && rd_id == wb_rd)) h = 1'b1;
        cnt = pending.size() - (clr ? 1 : 0);
        return !flush && !h && (cnt < int'(MAX) || !wrm);
    endfunction

    function automatic void m_clock();
        bit rdy;
        if (rst) begin
            pending.delete();
            stall_m = 0;
            err_m = 1'b0;
            return;
        end
        rdy = m_ready();
        if (in_valid && !rdy && !flush && stall_m < SMAX) stall_m++;
        if (wb_valid && wb_rd != 0) begin
            if (m_busy(int'(wb_rd))) begin
                foreach (pending[i]) if (pending[i] == int'(wb_rd)) begin
                    pending.delete(i);
                    break;
                end
            end else begin
                err_m = 1'b1;
            end
        end
        if (in_valid && rdy && reg_write && rd_id != 0) pending.push_back(int'(rd_id));
    endfunction

    task automatic tick();
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; rs1_id = 0; rs2_id = 0; rd_id = 0; use_rs1 = 0; use_rs2 = 0;
        reg_write = 0; flush = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic issue_wr(input int r);
        idle();
        in_valid = 1; reg_write = 1; rd_id = 5'(r);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        in_valid = 1; reg_write = 1; rd_id = 5'd4;
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0 || inflight !== '0 || stall_cnt !== '0 || wb_err !== 1'b0 || issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%h inflight=%0d stall=%0d err=%b fire=%b, want all 0",
                     busy_vec, inflight, stall_cnt, wb_err, issue_fire);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0 || inflight !== '0) begin
            errors++;
            $display("FAIL reset_hold: busy=%h inflight=%0d, want 0/0", busy_vec, inflight);
        end
        idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_raw_hazard();
        do_reset();
        in_valid = 1; reg_write = 1; rd_id = 5'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (busy_vec !== 32'h20 || inflight !== IW'(1)) begin
            errors++; $display("FAIL raw_set: busy=%h inflight=%0d want 00000020/1", busy_vec, inflight);
        end
        idle();
        in_valid = 1; use_rs1 = 1; rs1_id = 5'd5;
        for (int i = 1; i <= 2; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_ready: got %b want 0", in_ready); end
            tick();
            checks++;
            if (stall_cnt !== CW'(i)) begin errors++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, i); end
        end
        wb_valid = 1; wb_rd = 5'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL raw_wb_bypass: ready=%b fire=%b want 1/1", in_ready, issue_fire);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0 || inflight !== '0 || stall_cnt !== CW'(2)) begin
            errors++; $display("FAIL raw_cleared: busy=%h inflight=%0d stall=%0d want 0/0/2", busy_vec, inflight, stall_cnt);
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 1; r <= 4; r++) issue_wr(r);
        checks++;
        if (inflight !== IW'(4) || busy_vec !== 32'h1E) begin
            errors++; $display("FAIL full_count: inflight=%0d busy=%h want 4/0000001e", inflight, busy_vec);
        end
        in_valid = 1; reg_write = 1; rd_id = 5'd6;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %b want 0", in_ready); end
        wb_valid = 1; wb_rd = 5'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_wb_free: got %b want 1", in_ready); end
        tick();
        checks++;
        if (inflight !== IW'(4) || busy_vec !== 32'h5C) begin
            errors++; $display("FAIL full_swap: inflight=%0d busy=%h want 4/0000005c", inflight, busy_vec);
        end
        idle();
    endtask

    task automatic test_same_rd();
        do_reset();
        issue_wr(7);
        in_valid = 1; reg_write = 1; rd_id = 5'd7; wb_valid = 1; wb_rd = 5'd7;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL same_rd_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (busy_vec !== 32'h80 || inflight !== IW'(1)) begin
            errors++; $display("FAIL same_rd_state: busy=%h inflight=%0d want 00000080/1", busy_vec, inflight);
        end
        idle();
    endtask

    task automatic test_wb_err();
        do_reset();
        wb_valid = 1; wb_rd = 5'd0;
        tick();
        checks++;
        if (wb_err !== 1'b0) begin errors++; $display("FAIL wb_x0_ignored: got %b want 0", wb_err); end
        wb_rd = 5'd9;
        tick();
        checks++;
        if (wb_err !== 1'b1 || busy_vec !== 32'h0 || inflight !== '0) begin
            errors++; $display("FAIL wb_err_set: err=%b busy=%h inflight=%0d want 1/0/0", wb_err, busy_vec, inflight);
        end
        idle();
        repeat (3) tick();
        checks++;
        if (wb_err !== 1'b1) begin errors++; $display("FAIL wb_err_sticky: got %b want 1", wb_err); end
    endtask

    task automatic test_x0_flush();
        do_reset();
        issue_wr(3);
        in_valid = 1; reg_write = 1; rd_id = 5'd0; use_rs1 = 1; rs1_id = 5'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL x0_ready: ready=%b fire=%b want 1/1", in_ready, issue_fire);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h8 || inflight !== IW'(1)) begin
            errors++; $display("FAIL x0_state: busy=%h inflight=%0d want 00000008/1", busy_vec, inflight);
        end
        idle();
        in_valid = 1; reg_write = 1; rd_id = 5'd10; flush = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        checks++;
        if (stall_cnt !== '0 || busy_vec !== 32'h8 || inflight !== IW'(1)) begin
            errors++; $display("FAIL flush_state: stall=%0d busy=%h inflight=%0d want 0/00000008/1", stall_cnt, busy_vec, inflight);
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int r = 1; r <= 3; r++) issue_wr(r);
        checks++;
        if (inflight !== IW'(3)) begin errors++; $display("FAIL areset_pre: inflight=%0d want 3", inflight); end
        in_valid = 1; reg_write = 1; rd_id = 5'd8;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || inflight !== '0 || stall_cnt !== '0 || wb_err !== 1'b0 || issue_fire !== 1'b0) begin
            errors++; $display("FAIL areset_async: busy=%h inflight=%0d stall=%0d err=%b fire=%b want all 0",
                                busy_vec, inflight, stall_cnt, wb_err, issue_fire);
        end
        idle();
        #1 rst = 1'b0;
        pending.delete(); stall_m = 0; err_m = 1'b0;
        @(negedge clk);
        wb_valid = 1; wb_rd = 5'd2;
        tick();
        checks++;
        if (wb_err !== 1'b1) begin errors++; $display("FAIL areset_stale_wb: err=%b want 1", wb_err); end
        // Saturation of the stall counter.
        do_reset();
        issue_wr(5);
        in_valid = 1; use_rs1 = 1; rs1_id = 5'd5;
        repeat (SMAX + 4) tick();
        checks++;
        if (stall_cnt !== CW'(SMAX)) begin errors++; $display("FAIL stall_saturate: got %0d want %0d", stall_cnt, SMAX); end
        idle();
    endtask

    task automatic test_random();
        bit exp_rdy;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            rst       = ($urandom_range(0, 99) < 2);
            in_valid  = $urandom_range(0, 3) != 0;
            rs1_id    = 5'($urandom_range(0, 7));
            rs2_id    = 5'($urandom_range(0, 7));
            rd_id     = 5'($urandom_range(0, 9));
            use_rs1   = $urandom_range(0, 1);
            use_rs2   = $urandom_range(0, 1);
            reg_write = $urandom_range(0, 3) != 0;
            flush     = ($urandom_range(0, 9) == 0);
            wb_valid  = $urandom_range(0, 2) != 0;
            if (pending.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rd = 5'(pending[$urandom_range(0, pending.size() - 1)]);
            else
                wb_rd = 5'($urandom_range(0, 12));
            #1;
            exp_rdy = m_ready();
            checks++;
            if (!rst && (in_ready !== exp_rdy || issue_fire !== (in_valid && exp_rdy))) begin
                errors++; $display("FAIL rand_ready[%0d]: ready=%b fire=%b want %b/%b", n, in_ready, issue_fire, exp_rdy, in_valid && exp_rdy);
            end
            tick();
            rst = 1'b0;
            checks++;
            if (busy_vec !== m_vec() || int'(inflight) != pending.size() ||
                int'(stall_cnt) != stall_m || wb_err !== err_m) begin
                errors++; $display("FAIL rand_state[%0d]: busy=%h inflight=%0d stall=%0d err=%b want %h/%0d/%0d/%b",
                                   n, busy_vec, inflight, stall_cnt, wb_err, m_vec(), pending.size(), stall_m, err_m);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_full();
        test_same_rd();
        test_wb_err();
        test_x0_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter: MAX_INFLIGHT, default 4, maximum outstanding register-writing instructions.
REQ-002 SHALL have parameter: CNT_W, default 16, width of stall counter.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  decoded instruction presented for issue.
REQ-006 SHALL have port: in_ready  output  1  instruction may issue this cycle (combinational).
REQ-007 SHALL have ports: rs1_id, rs2_id, rd_id  input  5 each  register indices from decoder.
REQ-008 SHALL have ports: use_rs1, use_rs2  input  1 each  instruction reads rs1 / rs2.
REQ-009 SHALL have port: reg_write  input  1  instruction writes rd (decoder RegWrite).
REQ-010 SHALL have port: flush  input  1  pipeline flush; blocks issue this cycle.
REQ-011 SHALL have ports: wb_valid  input  1, wb_rd  input  5  writeback completion of rd.
REQ-012 SHALL have port: issue_fire  output  1  in_valid && in_ready.
REQ-013 SHALL have port: busy_vec  output  32  registered pending-write bit per register.
REQ-014 SHALL have port: inflight  output  $clog2(MAX_INFLIGHT+1)  registered outstanding count.
REQ-015 SHALL have port: stall_cnt  output  CNT_W  registered saturating stall-cycle counter.
REQ-016 SHALL have port: wb_err  output  1  registered sticky writeback-protocol error.

Function
REQ-017 busy_vec[0] SHALL be constant 0; x0 never pending.
REQ-018 wb_clr SHALL be wb_valid && wb_rd!=0 && busy_vec[wb_rd]; busy_eff = busy_vec with bit wb_rd cleared when wb_clr.
REQ-019 hazard SHALL be (use_rs1 && rs1_id!=0 && busy_eff[rs1_id]) || (use_rs2 && rs2_id!=0 && busy_eff[rs2_id]) || (wr && busy_eff[rd_id]), wr = reg_write && rd_id!=0.
REQ-020 in_ready SHALL be !flush && !hazard && (inflight - wb_clr < MAX_INFLIGHT || !wr); same-cycle writeback frees both register and slot.
REQ-021 in_ready SHALL not depend on in_valid.
REQ-022 Next busy_vec SHALL be busy_eff OR (issue_fire && wr ? onehot(rd_id) : 0); issue set wins over clear on same index.
REQ-023 Next inflight SHALL be inflight + (issue_fire && wr) - wb_clr; never exceeds MAX_INFLIGHT, never underflows.
REQ-024 reg_write with rd_id==0 SHALL issue without setting busy or incrementing inflight.
REQ-025 wb_valid with wb_rd!=0 and busy_vec[wb_rd]==0 SHALL set wb_err next cycle and leave state unchanged; wb_rd==0 SHALL be ignored without error.
REQ-026 wb_err SHALL stay 1 until reset.
REQ-027 stall_cnt SHALL increment by 1 each cycle in_valid && !in_ready && !flush, saturating at all-ones.
REQ-028 flush SHALL not clear busy_vec or inflight; outstanding writebacks still complete.
REQ-029 Latency: issue at edge N SHALL appear in busy_vec/inflight after edge N; writeback clear effective combinationally in cycle N.

Reset
REQ-030 On rst high, busy_vec, inflight, stall_cnt, wb_err SHALL go to 0 immediately, independent of clk.
REQ-031 While rst high, issue_fire SHALL be 0 and state SHALL not change; in_ready may be asserted but is ignored.
REQ-032 Reset deasserted mid-operation SHALL discard all pending state; later writebacks to cleared registers SHALL flag wb_err.

Verification
REQ-033 Issue rd=5 reg_write; next cycle in_valid rs1=5 use_rs1 -> in_ready=0, stall_cnt increments 1/cycle; wb_valid wb_rd=5 -> in_ready=1 same cycle, busy_vec[5]=0 after edge.
REQ-034 Issue 4 writes rd=1..4 back-to-back -> inflight=4; 5th write rd=6 -> in_ready=0; same cycle wb_rd=1 -> issues, inflight stays 4.
REQ-035 Issue rd=7 with simultaneous wb_rd=7 (busy) -> busy_vec[7]=1 after edge, inflight unchanged.
REQ-036 wb_valid wb_rd=9 with busy_vec[9]=0 -> wb_err=1 next cycle, persists; wb_rd=0 -> no error.
REQ-037 reg_write rd=0, rs1=0 use_rs1 while busy_vec nonzero -> issues, busy_vec and inflight unchanged; flush=1 -> in_ready=0, stall_cnt unchanged.
REQ-038 rst pulse mid-cycle with inflight=3 -> all outputs 0 asynchronously; stall_cnt forced to all-ones then held stalled -> stays all-ones.
